// File: rtl/mem_seq_pkg.sv
// Shared FSM states, grant encoding and port geometry for mem_port_sequencer.
package mem_seq_pkg;
  localparam int S      = 32;
  localparam int V      = 192;
  localparam int AW     = 16;
  localparam int BW     = 8;
  localparam int LANES  = V / S;
  localparam int LW     = $clog2(LANES);
  localparam int CW     = BW + 1;
  localparam int RD_LAT = 1;

  typedef enum logic [1:0] {IDLE, CPU_XFER, VGA_BURST, DRAIN} state_t;
  typedef enum logic {GNT_CPU = 1'b0, GNT_VGA = 1'b1} gnt_t;
endpackage

// File: rtl/lane_assembler.sv
// Rebuilds the 192-bit load result from word beats; one write per cycle, cleared by reset.
module lane_assembler
  import mem_seq_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_wr_en,
  input  logic          i_scalar,
  input  logic [LW-1:0] i_lane,
  input  logic [S-1:0]  i_wd,
  output logic [V-1:0]  o_data
);

  logic [V-1:0] r_data;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_data <= '0;
    end else if (i_wr_en) begin
      if (i_scalar) begin
        r_data <= {{(V-S){1'b0}}, i_wd};
      end else begin
        r_data[int'(i_lane)*S +: S] <= i_wd;
      end
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/mem_port_sequencer.sv
// Shares one 32-bit RAM port between CPU scalar/vector accesses and VGA read bursts.
// MEM_SEQ_PERF_EN adds saturating stall / VGA-word counters (ports tied to 0 otherwise).
module mem_port_sequencer
  import mem_seq_pkg::*;
(
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_cpu_req,
  input  logic          i_cpu_we,
  input  logic          i_cpu_vec,
  input  logic [AW-1:0] i_cpu_addr,
  input  logic [V-1:0]  i_cpu_wd,
  output logic [V-1:0]  o_cpu_rd,
  output logic          o_cpu_done,
  output logic          o_cpu_stall,
  input  logic          i_vga_req,
  input  logic [AW-1:0] i_vga_addr,
  input  logic [BW-1:0] i_vga_len,
  output logic          o_vga_gnt,
  output logic          o_vga_rvalid,
  output logic [S-1:0]  o_vga_rdata,
  output logic [AW-1:0] o_ram_addr,
  output logic          o_ram_we,
  output logic [S-1:0]  o_ram_wd,
  input  logic [S-1:0]  i_ram_rd,
  output logic [31:0]   o_perf_stall_cnt,
  output logic [31:0]   o_perf_vga_words
);

  state_t        r_state, w_state_nxt;
  gnt_t          r_last_gnt;
  logic [CW-1:0] r_beat, r_len;
  logic [AW-1:0] r_base, r_ram_addr;
  logic [V-1:0]  r_wd;
  logic [S-1:0]  r_ram_wd;
  logic          r_we, r_vec, r_owner_cpu, r_ram_we;
  logic          r_cpu_done, r_vga_gnt, r_vga_rvalid;
  logic          r_cap_vld;
  logic [LW-1:0] r_cap_lane;

  logic          w_cpu_req, w_grant_cpu, w_grant_vga, w_last_beat, w_busy, w_cpu_stall;
  logic [LW-1:0] w_nxt_lane;

  // A request seen in the completion cycle belongs to the access that just finished.
  assign w_cpu_req   = i_cpu_req & ~r_cpu_done;
  assign w_last_beat = (r_beat == r_len - CW'(1));
  assign w_busy      = (r_state == CPU_XFER) || (r_state == VGA_BURST);
  assign w_nxt_lane  = r_beat[LW-1:0] + LW'(1);
  assign w_cpu_stall = i_cpu_req & ~r_cpu_done & ~i_rst;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant_cpu = 1'b0;
    w_grant_vga = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_vga_req && (!w_cpu_req || r_last_gnt == GNT_CPU)) begin
          w_grant_vga = 1'b1;
          w_state_nxt = VGA_BURST;
        end else if (w_cpu_req) begin
          w_grant_cpu = 1'b1;
          w_state_nxt = CPU_XFER;
        end
      end
      CPU_XFER, VGA_BURST: begin
        if (w_last_beat) w_state_nxt = DRAIN;
      end
      DRAIN:   w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_gnt   <= GNT_CPU;
      r_beat       <= '0;
      r_len        <= '0;
      r_base       <= '0;
      r_wd         <= '0;
      r_we         <= 1'b0;
      r_vec        <= 1'b0;
      r_owner_cpu  <= 1'b0;
      r_ram_addr   <= '0;
      r_ram_we     <= 1'b0;
      r_ram_wd     <= '0;
      r_cpu_done   <= 1'b0;
      r_vga_gnt    <= 1'b0;
      r_vga_rvalid <= 1'b0;
      r_cap_vld    <= 1'b0;
      r_cap_lane   <= '0;
    end else begin
      r_cpu_done   <= (r_state == DRAIN) && r_owner_cpu;
      r_vga_gnt    <= w_grant_vga;
      r_vga_rvalid <= (r_state == VGA_BURST);
      // RAM data lags the address by one cycle, so capture uses last cycle's beat number.
      r_cap_vld    <= (r_state == CPU_XFER) && !r_we;
      r_cap_lane   <= r_beat[LW-1:0];
      if (w_grant_cpu) begin
        r_last_gnt  <= GNT_CPU;
        r_owner_cpu <= 1'b1;
        r_beat      <= '0;
        r_len       <= i_cpu_vec ? CW'(LANES) : CW'(1);
        r_base      <= i_cpu_addr;
        r_wd        <= i_cpu_wd;
        r_we        <= i_cpu_we;
        r_vec       <= i_cpu_vec;
        r_ram_addr  <= i_cpu_addr;
        r_ram_we    <= i_cpu_we;
        r_ram_wd    <= i_cpu_wd[S-1:0];
      end else if (w_grant_vga) begin
        r_last_gnt  <= GNT_VGA;
        r_owner_cpu <= 1'b0;
        r_beat      <= '0;
        r_len       <= (i_vga_len == '0) ? {1'b1, {BW{1'b0}}} : {1'b0, i_vga_len};
        r_base      <= i_vga_addr;
        r_ram_addr  <= i_vga_addr;
        r_ram_we    <= 1'b0;
      end else if (w_busy) begin
        if (w_last_beat) begin
          r_ram_we <= 1'b0;
        end else begin
          r_beat     <= r_beat + CW'(1);
          r_ram_addr <= r_base + AW'(r_beat + CW'(1));
          if (r_state == CPU_XFER) r_ram_wd <= r_wd[int'(w_nxt_lane)*S +: S];
        end
      end
    end
  end

  lane_assembler u_lane_asm (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_wr_en  (r_cap_vld),
    .i_scalar (~r_vec),
    .i_lane   (r_cap_lane),
    .i_wd     (i_ram_rd),
    .o_data   (o_cpu_rd)
  );

  assign o_cpu_done   = r_cpu_done;
  assign o_cpu_stall  = w_cpu_stall;
  assign o_vga_gnt    = r_vga_gnt;
  assign o_vga_rvalid = r_vga_rvalid;
  assign o_vga_rdata  = r_vga_rvalid ? i_ram_rd : '0;
  assign o_ram_addr   = r_ram_addr;
  assign o_ram_we     = r_ram_we;
  assign o_ram_wd     = r_ram_wd;

`ifdef MEM_SEQ_PERF_EN
  logic [31:0] r_perf_stall, r_perf_vga;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_perf_stall <= '0;
      r_perf_vga   <= '0;
    end else begin
      if (w_cpu_stall && r_perf_stall != '1) r_perf_stall <= r_perf_stall + 32'd1;
      if (r_vga_rvalid && r_perf_vga != '1) r_perf_vga <= r_perf_vga + 32'd1;
    end
  end

  assign o_perf_stall_cnt = r_perf_stall;
  assign o_perf_vga_words = r_perf_vga;
`else
  assign o_perf_stall_cnt = '0;
  assign o_perf_vga_words = '0;
`endif

endmodule

// File: tb/tb_mem_port_sequencer.sv
// Bench for mem_port_sequencer: RAM model, per-cycle timeline model, directed scenarios.
module tb_mem_port_sequencer;
  import mem_seq_pkg::*;

  localparam int NC = 4096;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, cpu_vec;
  logic [AW-1:0] cpu_addr;
  logic [V-1:0]  cpu_wd;
  logic [V-1:0]  cpu_rd;
  logic          cpu_done, cpu_stall;
  logic          vga_req;
  logic [AW-1:0] vga_addr;
  logic [BW-1:0] vga_len;
  logic          vga_gnt, vga_rvalid;
  logic [S-1:0]  vga_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [S-1:0]  ram_wd, ram_rd;
  logic [31:0]   perf_stall, perf_vwords;

  always #5 clk = ~clk;

  mem_port_sequencer dut (
    .i_clk(clk), .i_rst(rst),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_vec(cpu_vec),
    .i_cpu_addr(cpu_addr), .i_cpu_wd(cpu_wd), .o_cpu_rd(cpu_rd),
    .o_cpu_done(cpu_done), .o_cpu_stall(cpu_stall),
    .i_vga_req(vga_req), .i_vga_addr(vga_addr), .i_vga_len(vga_len),
    .o_vga_gnt(vga_gnt), .o_vga_rvalid(vga_rvalid), .o_vga_rdata(vga_rdata),
    .o_ram_addr(ram_addr), .o_ram_we(ram_we), .o_ram_wd(ram_wd), .i_ram_rd(ram_rd),
    .o_perf_stall_cnt(perf_stall), .o_perf_vga_words(perf_vwords)
  );

  function automatic logic [31:0] init_word(input logic [15:0] a);
    if (a == 16'h0010) return 32'hDEADBEEF;
    return {a ^ 16'hA5A5, a};
  endfunction

  // RAM with registered read
  logic [31:0] ram [65536];
  bit          ram_w [65536];
  always @(posedge clk) begin
    ram_rd <= ram_w[ram_addr] ? ram[ram_addr] : init_word(ram_addr);
    if (ram_we) begin
      ram[ram_addr]   <= ram_wd;
      ram_w[ram_addr] <= 1'b1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  task automatic chk(input string name, input logic [V-1:0] act, input logic [V-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  // Timeline model: on each grant the whole access is laid out on future cycles.
  logic [31:0]   mmem [65536];
  bit            mw [65536];
  logic [AW-1:0] e_addr [NC];
  bit            e_addr_v [NC];
  bit            e_we [NC];
  logic [31:0]   e_wd [NC];
  bit            e_done [NC];
  bit            e_gnt [NC];
  bit            e_rv [NC];
  logic [31:0]   e_rdata [NC];
  bit            e_rdv [NC];
  logic [V-1:0]  e_rd [NC];
  logic [AW-1:0] cur_addr = '0;
  bit            rd_ok = 1'b1;
  logic [V-1:0]  cur_rd = '0;
  int            free_at = 0;
  bit            last_vga = 1'b0;
  int            m_stall = 0, m_vwords = 0;

  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    return mw[a] ? mmem[a] : init_word(a);
  endfunction

  task automatic sched_cpu(input int t);
    int n;
    logic [AW-1:0] a;
    logic [V-1:0] rdv;
    n = cpu_vec ? 6 : 1;
    rdv = '0;
    for (int k = 0; k < n; k++) begin
      a = cpu_addr + AW'(k);
      e_addr_v[t+1+k] = 1'b1;
      e_addr[t+1+k]   = a;
      e_we[t+1+k]     = cpu_we;
      e_wd[t+1+k]     = cpu_wd[k*32 +: 32];
      if (cpu_we) begin
        mmem[a] = cpu_wd[k*32 +: 32];
        mw[a]   = 1'b1;
      end else begin
        rdv[k*32 +: 32] = mem_rd(a);
      end
    end
    e_done[t+n+2] = 1'b1;
    if (!cpu_we) begin
      e_rdv[t+n+2] = 1'b1;
      e_rd[t+n+2]  = rdv;
      rd_ok = 1'b0;
    end
    free_at  = t + n + 2;
    last_vga = 1'b0;
  endtask

  task automatic sched_vga(input int t);
    int l;
    logic [AW-1:0] a;
    l = (vga_len == 0) ? 256 : int'(vga_len);
    e_gnt[t+1] = 1'b1;
    for (int k = 0; k < l; k++) begin
      a = vga_addr + AW'(k);
      e_addr_v[t+1+k] = 1'b1;
      e_addr[t+1+k]   = a;
      e_rv[t+2+k]     = 1'b1;
      e_rdata[t+2+k]  = mem_rd(a);
    end
    free_at  = t + l + 2;
    last_vga = 1'b1;
  endtask

  always @(negedge clk) begin
    bit st, creq;
    if (cyc + 300 < NC) begin
      if (e_addr_v[cyc]) cur_addr = e_addr[cyc];
      if (e_rdv[cyc]) begin
        rd_ok  = 1'b1;
        cur_rd = e_rd[cyc];
      end
      st = cpu_req && !e_done[cyc] && !rst;
      if (cyc >= 1) begin
        chk("ram_addr", V'(ram_addr), V'(cur_addr));
        chk("ram_we", V'(ram_we), V'(e_we[cyc]));
        if (e_we[cyc]) chk("ram_wd", V'(ram_wd), V'(e_wd[cyc]));
        chk("cpu_done", V'(cpu_done), V'(e_done[cyc]));
        chk("cpu_stall", V'(cpu_stall), V'(st));
        chk("vga_gnt", V'(vga_gnt), V'(e_gnt[cyc]));
        chk("vga_rvalid", V'(vga_rvalid), V'(e_rv[cyc]));
        chk("vga_rdata", V'(vga_rdata), V'(e_rv[cyc] ? e_rdata[cyc] : 32'h0));
        if (rd_ok) chk("cpu_rd", cpu_rd, cur_rd);
`ifdef MEM_SEQ_PERF_EN
        chk("perf_stall", V'(perf_stall), V'(m_stall));
        chk("perf_vga_words", V'(perf_vwords), V'(m_vwords));
`else
        chk("perf_stall_tied", V'(perf_stall), V'(0));
        chk("perf_vga_words_tied", V'(perf_vwords), V'(0));
`endif
      end
      if (rst) begin
        for (int c = cyc + 1; c < NC; c++) begin
          e_addr_v[c] = 1'b0; e_we[c] = 1'b0; e_done[c] = 1'b0;
          e_gnt[c] = 1'b0; e_rv[c] = 1'b0; e_rdv[c] = 1'b0;
        end
        e_addr_v[cyc+1] = 1'b1;
        e_addr[cyc+1]   = '0;
        e_rdv[cyc+1]    = 1'b1;
        e_rd[cyc+1]     = '0;
        free_at  = cyc + 1;
        last_vga = 1'b0;
        m_stall  = 0;
        m_vwords = 0;
      end else begin
        m_stall  += int'(st);
        m_vwords += int'(e_rv[cyc]);
        if (cyc >= free_at) begin
          creq = cpu_req && !e_done[cyc];
          if (vga_req && (!creq || !last_vga)) sched_vga(cyc);
          else if (creq) sched_cpu(cyc);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int at);
    at = -1;
    for (int i = 0; i < 30; i++) begin
      step();
      if (cpu_done) begin
        at = cyc;
        break;
      end
    end
    cpu_req = 1'b0;
  endtask

  int t0, at, nrv, ngnt, ndone;
  logic [V-1:0] vec_pat;

  initial begin
    rst = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_vec = 1'b0;
    cpu_addr = '0; cpu_wd = '0; vga_req = 1'b0; vga_addr = '0; vga_len = '0;
    vec_pat = {32'd6, 32'd5, 32'd4, 32'd3, 32'd2, 32'd1};
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("reset_cpu_rd", cpu_rd, '0);
    chk("reset_ram_addr", V'(ram_addr), V'(0));
    chk("reset_cpu_done", V'(cpu_done), V'(0));
    chk("reset_vga_rvalid", V'(vga_rvalid), V'(0));

    // Collision: VGA first after reset, then CPU, then VGA again
    t0 = cyc;
    vga_req = 1'b1; vga_addr = 16'h0100; vga_len = 8'd4;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_vec = 1'b0; cpu_addr = 16'h0020;
    step();
    chk("coll_vga_first", V'(vga_gnt), V'(1));
    vga_req = 1'b0;
    nrv = 0;
    repeat (4) begin
      step();
      nrv += int'(vga_rvalid);
    end
    chk("coll_rvalid_beats", V'(nrv), V'(4));
    chk("coll_stall_held", V'(cpu_stall), V'(1));
    vga_req = 1'b1;
    wait_done(at);
    chk("coll_cpu_done_cycle", V'(at - t0), V'(9));
    step();
    chk("coll_vga_regrant", V'(vga_gnt), V'(1));
    vga_req = 1'b0;
`ifdef MEM_SEQ_PERF_EN
    chk("coll_perf_vga_words", V'(perf_vwords), V'(4));
    chk("coll_perf_stall", V'(perf_stall), V'(9));
`else
    chk("coll_perf_vga_words", V'(perf_vwords), V'(0));
    chk("coll_perf_stall", V'(perf_stall), V'(0));
`endif
    repeat (8) step();

    // Scalar load
    t0 = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_vec = 1'b0; cpu_addr = 16'h0010;
    cpu_wd = {6{32'h5A5A_1234}};
    step();
    chk("sl_ram_addr", V'(ram_addr), V'(16'h0010));
    wait_done(at);
    chk("sl_done_cycle", V'(at - t0), V'(3));
    chk("sl_cpu_rd", cpu_rd, {160'b0, 32'hDEADBEEF});
    step();

    // Vector store across the address wrap, then reload
    t0 = cyc;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_vec = 1'b1; cpu_addr = 16'hFFFE; cpu_wd = vec_pat;
    wait_done(at);
    chk("vs_done_cycle", V'(at - t0), V'(8));
    step(); step();
    chk("vs_ram_fffe", V'(ram[16'hFFFE]), V'(1));
    chk("vs_ram_ffff", V'(ram[16'hFFFF]), V'(2));
    chk("vs_ram_0000", V'(ram[16'h0000]), V'(3));
    chk("vs_ram_0003", V'(ram[16'h0003]), V'(6));
    t0 = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_wd = '0;
    wait_done(at);
    chk("vl_done_cycle", V'(at - t0), V'(8));
    chk("vl_cpu_rd", cpu_rd, vec_pat);
    step();

    // Burst length 0 means 256 words
    vga_req = 1'b1; vga_addr = 16'h0200; vga_len = 8'd0;
    step();
    chk("vga256_gnt", V'(vga_gnt), V'(1));
    vga_req = 1'b0;
    nrv = 0; ngnt = 0;
    repeat (300) begin
      step();
      nrv  += int'(vga_rvalid);
      ngnt += int'(vga_gnt);
    end
    chk("vga256_beats", V'(nrv), V'(256));
    chk("vga256_single_gnt", V'(ngnt), V'(0));

    // Reset during beat 3 of a vector load
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_vec = 1'b1; cpu_addr = 16'h0030;
    repeat (4) step();
    chk("rst_beat3_addr", V'(ram_addr), V'(16'h0033));
    rst = 1'b1; cpu_req = 1'b0;
    step();
    rst = 1'b0;
    chk("rst_cpu_rd", cpu_rd, '0);
    chk("rst_ram_addr", V'(ram_addr), V'(0));
    chk("rst_ram_we", V'(ram_we), V'(0));
    chk("rst_cpu_done", V'(cpu_done), V'(0));
    chk("rst_cpu_stall", V'(cpu_stall), V'(0));
    chk("rst_vga_rvalid", V'(vga_rvalid), V'(0));
    chk("rst_vga_gnt", V'(vga_gnt), V'(0));
    ndone = 0;
    repeat (15) begin
      step();
      ndone += int'(cpu_done);
    end
    chk("rst_no_done", V'(ndone), V'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_sequencer.md
Name: mem_port_sequencer

Overview:
- Owns the single 32-bit data RAM port used by the memory stage and shares it between two requesters.
- Requester 1 is the CPU memory stage: scalar or 192-bit vector load/store.
- Requester 2 is the VGA scan-out line fetcher, which issues read bursts.
- Vector accesses are split into 6 sequential word beats, and the 192-bit read result is reassembled; the CPU is stalled for the whole transfer.

Parameters:
- S, 32, scalar/RAM word width
- V, 192, vector width; LANES = V/S = 6
- AW, 16, RAM word-address width
- BW, 8, VGA burst-length field width

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- cpu_req  in  1  CPU access request; held until cpu_done
- cpu_we  in  1  1 = store, 0 = load
- cpu_vec  in  1  1 = vector (6 beats), 0 = scalar (1 beat)
- cpu_addr  in  AW  base word address
- cpu_wd  in  V  store data; scalar uses [S-1:0]
- cpu_rd  out  V  load result; scalar zero-extended
- cpu_done  out  1  one-cycle completion pulse
- cpu_stall  out  1  pipeline stall request
- vga_req  in  1  burst request
- vga_addr  in  AW  burst start address
- vga_len  in  BW  burst length in words; 0 means 2^BW
- vga_gnt  out  1  one-cycle pulse when the burst starts
- vga_rvalid  out  1  vga_rdata valid
- vga_rdata  out  S  burst read word
- ram_addr  out  AW  RAM address
- ram_we  out  1  RAM write enable
- ram_wd  out  S  RAM write data
- ram_rd  in  S  RAM read data, registered, 1-cycle latency

Behaviour:
- Reset values: all outputs 0; state IDLE; beat counter 0.
- Reset mid-transfer aborts immediately:
  - in-flight read data is discarded;
  - no cpu_done and no further vga_rvalid are produced.
- FSM states: IDLE, CPU_XFER, VGA_BURST, DRAIN.
- IDLE arbitration:
  - Only vga_req: go to VGA_BURST.
  - Only cpu_req: go to CPU_XFER.
  - Both requested: VGA wins, unless the previous grant was VGA, in which case CPU wins (alternating; no starvation).
  - cpu_req is ignored in the cycle cpu_done is high.
- Request sampling: requests are sampled in IDLE at cycle T.
- Address issue: beat k issues at cycle T+1+k.
  - ram_addr = base + k, modulo 2^AW (wraps).
- CPU_XFER:
  - N = 6 if cpu_vec, else N = 1.
  - Addresses, cpu_we, cpu_vec and cpu_wd are latched at T; later changes are ignored.
  - Store: ram_we = 1 and ram_wd = cpu_wd[k*S +: S] for each beat.
  - Load: ram_we = 0; the data at cycle T+2+k is captured into cpu_rd lane k.
  - After the last beat the FSM goes to DRAIN.
- DRAIN: one cycle, ram_we = 0. Then back to IDLE.
  - cpu_done pulses at T+N+2 for loads and stores alike.
  - cpu_rd is valid from the cpu_done cycle and holds until the next CPU load starts.
- cpu_stall = cpu_req & ~cpu_done.
  - It also stalls while a VGA burst blocks the CPU.
- cpu_req dropped mid-transfer: the transfer still completes and cpu_done still pulses.
- VGA_BURST:
  - vga_gnt pulses at T+1.
  - L beats read vga_addr + k (wrapping); ram_we = 0.
  - vga_rvalid is high exactly L cycles, T+2 .. T+L+1, with vga_rdata = ram_rd.
  - Then DRAIN (the drain cycle overlaps the last vga_rvalid).
- ram_addr: holds its last value when idle; ram_we is never high outside CPU_XFER.

Optional Feature:
- Macro: MEM_SEQ_PERF_EN.
- With the macro defined:
  - Extra output perf_stall_cnt [31:0] counts cycles with cpu_stall = 1.
  - Extra output perf_vga_words [31:0] counts vga_rvalid cycles.
  - Both counters saturate at 2^32-1 and are cleared by rst.
- Without the macro: the ports are still present but tied to 0, and no counter logic is generated.

Decomposition:
- Package mem_seq_pkg:
  - state enum (IDLE, CPU_XFER, VGA_BURST, DRAIN);
  - LANES = 6 and RD_LAT = 1;
  - last-grant encoding (GNT_CPU, GNT_VGA).
- Sub-module lane_assembler:
  - 192-bit register with per-lane write enable, indexed by a beat-delayed lane number;
  - clear on rst;
  - scalar zero-extend mode.

Test Plan:
- Scalar load: cpu_addr=0x0010, RAM[0x10]=0xDEADBEEF, cpu_req at T → ram_addr=0x10 at T+1; cpu_done at T+3; cpu_rd=0x…0DEADBEEF with upper 160 bits 0.
- Vector store then load: cpu_wd lanes 0..5 = 1..6 at base 0xFFFE → writes hit 0xFFFE, 0xFFFF, 0x0000..0x0003 (wrap); cpu_done at T+8; reload returns lanes 1..6.
- Collision: vga_req (len=4) and cpu_req together in IDLE, last grant CPU → VGA first, vga_rvalid 4 cycles. Next cycle both again → CPU wins next. cpu_stall high throughout until cpu_done.
- vga_len=0 → exactly 256 vga_rvalid beats at sequential addresses, single vga_gnt pulse.
- rst asserted at beat 3 of a vector load → next cycle all outputs 0 and state IDLE; no cpu_done afterwards.
- With MEM_SEQ_PERF_EN defined, run the collision test → perf_vga_words=4 and perf_stall_cnt equals the counted stall cycles. Without the macro both read 0.
